// File: rtl/spi_recv_con_if.sv
// Link and result signals of the parallel SPI receiver.
// The master side drives the link; the slave side is the receiver.
interface spi_recv_con_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LINES      = 6
);
  logic [LINES-1:0]                 chip_data_in;
  logic                             chip_clk_in;
  logic                             chip_sel_in;
  logic [LINES-1:0][DATA_WIDTH-1:0] data_out;
  logic                             data_valid_out;
  logic                             frame_error_out;

  modport master (
    output chip_data_in, chip_clk_in, chip_sel_in,
    input  data_out, data_valid_out, frame_error_out
  );

  modport slave (
    input  chip_data_in, chip_clk_in, chip_sel_in,
    output data_out, data_valid_out, frame_error_out
  );
endinterface

// File: rtl/spi_recv_con.sv
// Multi-line SPI receiver: synchronizes DCLK/CS/COPI and deserializes one word per line.
// Posts complete words with a one-cycle valid strobe and flags truncated frames.
module spi_recv_con #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINES       = 6,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  spi_recv_con_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RECV  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][LINES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0]            clk_sync_r;
  logic [SYNC_STAGES-1:0]            cs_sync_r;
  logic                              clk_prev_r;
  logic                              cs_prev_r;
  logic [SYNC_STAGES:0]              flush_r;

  state_t                           state_r, state_nxt_s;
  logic [CNT_W-1:0]                 cnt_r, cnt_nxt_s;
  logic [LINES-1:0][DATA_WIDTH-1:0] shift_r, shift_nxt_s, shifted_s;
  logic [LINES-1:0][DATA_WIDTH-1:0] data_r, data_nxt_s;
  logic                             valid_r, valid_nxt_s;
  logic                             err_pend_r, err_pend_nxt_s;
  logic                             err_r;

  logic             clk_rise_s, cs_rise_s, cs_fall_s, flush_done_s;
  logic [LINES-1:0] line_bits_s;

  // Input synchronizers and edge-detect history; CS idles high so its chain resets to 1.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_sync_r <= '0;
      clk_sync_r  <= '0;
      cs_sync_r   <= '1;
      clk_prev_r  <= 1'b0;
      cs_prev_r   <= 1'b1;
      flush_r     <= '0;
    end else begin
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], bus.chip_data_in};
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], bus.chip_clk_in};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.chip_sel_in};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
      cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
      flush_r     <= {flush_r[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign clk_rise_s   = clk_sync_r[SYNC_STAGES-1] & ~clk_prev_r;
  assign cs_rise_s    = cs_sync_r[SYNC_STAGES-1] & ~cs_prev_r;
  assign cs_fall_s    = ~cs_sync_r[SYNC_STAGES-1] & cs_prev_r;
  assign line_bits_s  = data_sync_r[SYNC_STAGES-1];
  // The reset-preset CS chain must be flushed before its high level is trusted.
  assign flush_done_s = flush_r[SYNC_STAGES];

  // Each line's shift register with the new synced bit entering at the LSB.
  always_comb begin
    shifted_s = shift_r;
    for (int i = 0; i < LINES; i++) begin
      shifted_s[i] = {shift_r[i][DATA_WIDTH-2:0], line_bits_s[i]};
    end
  end

  // Next-state and datapath decisions for the receive FSM.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    shift_nxt_s    = shift_r;
    data_nxt_s     = data_r;
    valid_nxt_s    = 1'b0;
    err_pend_nxt_s = 1'b0;
    case (state_r)
      ST_ARMED: begin
        if (flush_done_s && cs_sync_r[SYNC_STAGES-1]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = '0;
          state_nxt_s = ST_RECV;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (cnt_r == CNT_FULL) begin
          data_nxt_s  = shift_r;
          valid_nxt_s = 1'b1;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          cnt_nxt_s = cnt_r;
        end
        // CS rising wins over a coincident DCLK edge.
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
          if ((cnt_r != CNT_ZERO) && (cnt_r != CNT_FULL)) begin
            err_pend_nxt_s = 1'b1;
          end else begin
            err_pend_nxt_s = 1'b0;
          end
        end else if (clk_rise_s) begin
          shift_nxt_s = shifted_s;
          if (cnt_r == CNT_FULL) begin
            cnt_nxt_s = CNT_ONE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      default: begin
        state_nxt_s = ST_ARMED;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r <= ST_ARMED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers; the error strobe is delayed one cycle to match valid latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_r      <= CNT_ZERO;
      shift_r    <= '0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      err_pend_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      data_r     <= data_nxt_s;
      valid_r    <= valid_nxt_s;
      err_pend_r <= err_pend_nxt_s;
      err_r      <= err_pend_r;
    end
  end

  assign bus.data_out        = data_r;
  assign bus.data_valid_out  = valid_r;
  assign bus.frame_error_out = err_r;
endmodule

// File: tb/tb_spi_recv_con.sv
// Self-checking bench for spi_recv_con: table of frames plus hand-written reset and burst sequences.
module tb_spi_recv_con;
  localparam int DW   = 8;
  localparam int NL   = 6;
  localparam int SS   = 2;
  localparam int HALF = 50;

  typedef logic [NL-1:0][DW-1:0] words_t;

  typedef struct {
    words_t words;
    int     nbits;
    logic   exp_valid;
    logic   exp_err;
    words_t exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_recv_con_if #(.DATA_WIDTH(DW), .LINES(NL)) bus ();

  spi_recv_con #(.DATA_WIDTH(DW), .LINES(NL), .SYNC_STAGES(SS)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  int     valid_cnt = 0;
  int     err_cnt = 0;
  bit     both_seen = 1'b0;
  int     valid_cyc = -1;
  int     err_cyc = -1;
  int     last_rise_cyc = 0;
  int     cs_rise_cyc = 0;
  words_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.data_valid_out === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      got_q.push_back(bus.data_out);
    end
    if (bus.frame_error_out === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (bus.data_valid_out === 1'b1 && bus.frame_error_out === 1'b1) both_seen = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input words_t w, input int nb);
    logic [NL-1:0] bits;
    for (int b = 0; b < nb; b++) begin
      for (int l = 0; l < NL; l++) bits[l] = w[l][DW-1-b];
      @(negedge clk);
      bus.chip_data_in = bits;
      wait_cyc(HALF);
      bus.chip_clk_in = 1'b1;
      last_rise_cyc = cyc;
      wait_cyc(HALF);
      bus.chip_clk_in = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    bus.chip_sel_in = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic cs_end();
    wait_cyc(HALF);
    bus.chip_sel_in = 1'b1;
    cs_rise_cyc = cyc;
    wait_cyc(HALF);
  endtask

  vec_t   vecs[8];
  words_t v_a, v_b, v_c, v_d, b1, b2;
  int     v0, e0;

  initial begin
    v_a = {8'h3C, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hA5};
    v_b = {8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    v_c = {8'h3C, 8'hC3, 8'hFF, 8'h00, 8'h7F, 8'h80};
    v_d = {8'h66, 8'h99, 8'hAA, 8'h55, 8'h0F, 8'hF0};
    vecs[0] = '{v_a, 8, 1'b1, 1'b0, v_a};
    vecs[1] = '{{6{8'h5A}}, 5, 1'b0, 1'b1, v_a};
    vecs[2] = '{v_b, 8, 1'b1, 1'b0, v_b};
    vecs[3] = '{words_t'(0), 0, 1'b0, 1'b0, v_b};
    vecs[4] = '{v_c, 8, 1'b1, 1'b0, v_c};
    vecs[5] = '{{6{8'hFF}}, 1, 1'b0, 1'b1, v_c};
    vecs[6] = '{v_b, 7, 1'b0, 1'b1, v_c};
    vecs[7] = '{v_d, 8, 1'b1, 1'b0, v_d};

    bus.chip_data_in = '0;
    bus.chip_clk_in  = 1'b0;
    bus.chip_sel_in  = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    check("reset_data", 64'(bus.data_out), 64'h0);
    check("reset_valid", 64'(bus.data_valid_out), 64'h0);
    check("reset_err", 64'(bus.frame_error_out), 64'h0);
    rst = 1'b0;
    wait_cyc(100);
    check("idle_no_valid", 64'(valid_cnt), 64'd0);
    check("idle_no_err", 64'(err_cnt), 64'd0);

    for (int i = 0; i < 8; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      cs_start();
      if (vecs[i].nbits == 0) wait_cyc(300);
      else send_bits(vecs[i].words, vecs[i].nbits);
      cs_end();
      check($sformatf("vec%0d_valid_pulses", i), 64'(valid_cnt - v0), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_err_pulses", i), 64'(err_cnt - e0), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_data", i), 64'(bus.data_out), 64'(vecs[i].exp_data));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_valid_latency", i), 64'(valid_cyc - last_rise_cyc), 64'(SS + 2));
      if (vecs[i].exp_err)
        check($sformatf("vec%0d_err_latency", i), 64'(err_cyc - cs_rise_cyc), 64'(SS + 2));
    end

    // Burst: two words under one CS.
    b1 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12};
    b2 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h34};
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_start();
    send_bits(b1, 8);
    send_bits(b2, 8);
    cs_end();
    check("burst_valid_pulses", 64'(valid_cnt - v0), 64'd2);
    check("burst_err_pulses", 64'(err_cnt - e0), 64'd0);
    check("burst_word0", 64'(got_q[got_q.size()-2][0]), 64'h12);
    check("burst_word1", 64'(got_q[got_q.size()-1][0]), 64'h34);

    // Asynchronous reset between clock edges with CS high.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_data", 64'(bus.data_out), 64'h0);
    check("async_rst_valid", 64'(bus.data_valid_out), 64'h0);
    check("async_rst_err", 64'(bus.frame_error_out), 64'h0);
    wait_cyc(3);
    rst = 1'b0;
    v0 = valid_cnt;
    e0 = err_cnt;
    wait_cyc(100);
    check("post_rst_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("post_rst_no_err", 64'(err_cnt - e0), 64'd0);

    // Reset asserted mid-frame and released while CS is low and DCLK toggles.
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_start();
    send_bits(v_a, 4);
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    send_bits(v_a, 8);
    send_bits(v_b, 3);
    cs_end();
    check("midrst_no_valid", 64'(valid_cnt - v0), 64'd0);
    check("midrst_no_err", 64'(err_cnt - e0), 64'd0);
    check("midrst_data_cleared", 64'(bus.data_out), 64'h0);
    v0 = valid_cnt;
    e0 = err_cnt;
    cs_start();
    send_bits(v_c, 8);
    cs_end();
    check("after_midrst_valid", 64'(valid_cnt - v0), 64'd1);
    check("after_midrst_err", 64'(err_cnt - e0), 64'd0);
    check("after_midrst_data", 64'(bus.data_out), 64'(v_c));

    check("valid_err_never_together", 64'(both_seen), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
